comp_seq_ctrl: RTL and testbench

COMP_SEQ_CTRL -- requirements
Module: comp_seq_ctrl

---
 rtl/comp_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_comp_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/comp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// comp_seq_ctrl
//
// Purpose:
//   Serial magnitude comparator. Two WIDTH-bit operands A and B are loaded
//   one nibble at a time. They fill in this order: A low to high, then B low
//   to high. A start strobe then compares them bit-serially, MSB first, with
//   the 1-bit cascade rule. The l/g/e result registers change only when a
//   compare finishes, and a one-cycle done pulse marks each new result.
//
// Parameters:
//   WIDTH  operand width in bits. Only 8 and 16 are legal.
//
// Configuration macro:
//   COMP_SEQ_EARLY_EXIT_EN  when defined, a compare ends at the first bit
//                           where A and B differ. When undefined, all WIDTH
//                           bits are always evaluated, so latency is fixed.
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst    in   synchronous, active-high reset; has priority over load/start
//   inp    in   [3:0] nibble written into the next operand slot
//   load   in   strobe: write inp into the selected slot (IDLE only)
//   start  in   strobe: begin a compare (IDLE and ready only)
//   ready  out  all 2*WIDTH/4 nibble slots have been loaded
//   busy   out  a compare is in progress
//   done   out  one-cycle pulse: l/g/e carry a new result
//   l,g,e  out  A<B, A>B, A==B (one-hot, registered)
// -----------------------------------------------------------------------------
module comp_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] inp,
    input  logic       load,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       l,
    output logic       g,
    output logic       e
);

    localparam int SLOTS = 2 * WIDTH / 4;
    localparam int CW    = $clog2(SLOTS);
    localparam int IW    = $clog2(WIDTH);

    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);
    localparam logic [IW-1:0] MSB_IDX   = IW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      slot;
    logic [IW-1:0]      idx;
    logic               ready_q;

    // {B, A}: the slot order A low..high then B low..high means slot s is
    // simply nibble s of this concatenation.
    logic [2*WIDTH-1:0] opnd;
    logic [WIDTH-1:0]   a_op;
    logic [WIDTH-1:0]   b_op;

    // Cascade chain state used during a compare. It is kept separate from
    // the output registers so that intermediate values never reach l/g/e.
    logic               chain_l, chain_g, chain_e;
    logic               next_l, next_g, next_e;
    logic               a_bit, b_bit;
    logic               last_eval;

    logic               res_l, res_g, res_e;

    assign a_op  = opnd[WIDTH-1:0];
    assign b_op  = opnd[2*WIDTH-1:WIDTH];
    assign a_bit = a_op[idx];
    assign b_bit = b_op[idx];

    // One cascade step. Once the chain has left the equal state, l/g are
    // frozen, so the remaining bits cannot change the result.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves one unassigned would infer a latch.
        next_l = chain_l;
        next_g = chain_g;
        next_e = chain_e;
        if (chain_e) begin
            if (a_bit && !b_bit) begin
                next_g = 1'b1;
                next_e = 1'b0;
            end else if (!a_bit && b_bit) begin
                next_l = 1'b1;
                next_e = 1'b0;
            end
        end
    end

`ifdef COMP_SEQ_EARLY_EXIT_EN
    // Stop at the first differing bit. Equal operands still take WIDTH steps.
    assign last_eval = (idx == '0) || !next_e;
`else
    assign last_eval = (idx == '0);
`endif

    // NOTE: all state below uses non-blocking assignments, so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            slot    <= '0;
            idx     <= '0;
            ready_q <= 1'b0;
            opnd    <= '0;
            chain_l <= 1'b0;
            chain_g <= 1'b0;
            chain_e <= 1'b1;
            res_l   <= 1'b0;
            res_g   <= 1'b0;
            res_e   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start beats a simultaneous load; start without ready
                    // falls through, so that cycle's load is still accepted.
                    if (start && ready_q) begin
                        state   <= ST_CMP;
                        idx     <= MSB_IDX;
                        chain_l <= 1'b0;
                        chain_g <= 1'b0;
                        chain_e <= 1'b1;
                    end else if (load) begin
                        if (ready_q) begin
                            // Reload after a full set: restart at slot 0 and
                            // leave the other slots untouched.
                            opnd[0 +: 4] <= inp;
                            slot         <= CW'(1);
                            ready_q      <= 1'b0;
                        end else begin
                            opnd[{slot, 2'b00} +: 4] <= inp;
                            if (slot == LAST_SLOT) begin
                                slot    <= '0;
                                ready_q <= 1'b1;
                            end else begin
                                slot <= slot + 1'b1;
                            end
                        end
                    end
                end

                ST_CMP: begin
                    chain_l <= next_l;
                    chain_g <= next_g;
                    chain_e <= next_e;
                    if (last_eval) begin
                        state <= ST_DONE;
                        res_l <= next_l;
                        res_g <= next_g;
                        res_e <= next_e;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = (state == ST_CMP);
    assign done  = (state == ST_DONE);
    assign l     = res_l;
    assign g     = res_g;
    assign e     = res_e;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comp_seq_ctrl
//
// Purpose:
//   Directed testbench for comp_seq_ctrl with WIDTH=8. Inputs change 1 ns
//   after a rising edge, and outputs are sampled at that same point. The
//   expected compare latency follows COMP_SEQ_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_comp_seq_ctrl;

    localparam logic [2:0] LGE_L = 3'b100;
    localparam logic [2:0] LGE_G = 3'b010;
    localparam logic [2:0] LGE_E = 3'b001;

    logic       clk;
    logic       rst;
    logic [3:0] inp;
    logic       load;
    logic       start;
    logic       ready;
    logic       busy;
    logic       done;
    logic       l, g, e;

    int checks = 0;
    int errors = 0;

    comp_seq_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .inp   (inp),
        .load  (load),
        .start (start),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .l     (l),
        .g     (g),
        .e     (e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_nib(input logic [3:0] v);
        inp  = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Issue start at edge k, then count edges until done. When poke is set,
    // a load and a start are driven into the second CMP cycle; both must be
    // ignored. l/g/e must hold prev_lge until the done pulse.
    task automatic run_cmp(input string tag, input logic [2:0] exp_lge,
                           input int exp_lat, input logic [2:0] prev_lge,
                           input bit poke);
        int  n;
        bit  hold_ok;
        bit  busy_ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy@k"}, 32'(busy), 32'd1);
        n       = 0;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if ({l, g, e} !== prev_lge) hold_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke && n == 1) begin
                inp   = 4'h0;
                load  = 1'b1;
                start = 1'b1;
            end
            tick();
            load  = 1'b0;
            start = 1'b0;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " hold"}, 32'(hold_ok), 32'd1);
        check({tag, " busy_run"}, 32'(busy_ok), 32'd1);
        check({tag, " lge"}, 32'({l, g, e}), 32'(exp_lge));
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " ready_kept"}, 32'(ready), 32'd1);
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " lge_held"}, 32'({l, g, e}), 32'(exp_lge));
    endtask

    initial begin
        int  lat_gt;
        bit  saw;

`ifdef COMP_SEQ_EARLY_EXIT_EN
        lat_gt = 1;
`else
        lat_gt = 8;
`endif

        rst   = 1'b1;
        inp   = 4'hF;
        load  = 1'b1;   // reset must override load and start
        start = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        check("rst ready", 32'(ready), 32'd0);
        check("rst busy",  32'(busy),  32'd0);
        check("rst done",  32'(done),  32'd0);
        check("rst lge",   32'({l, g, e}), 32'(LGE_E));

        // A = B = 0x5A; start after three loads is ignored.
        load_nib(4'hA);
        load_nib(4'h5);
        load_nib(4'hA);
        check("3 loads ready", 32'(ready), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("early start busy", 32'(busy), 32'd0);
        tick();
        check("early start done", 32'(done), 32'd0);
        load_nib(4'h5);
        check("4 loads ready", 32'(ready), 32'd1);
        run_cmp("eq5A", LGE_E, 8, LGE_E, 1'b1);

        // A = 0x80, B = 0x7F: first load on a full set clears ready.
        load_nib(4'h0);
        check("reload ready", 32'(ready), 32'd0);
        load_nib(4'h8);
        load_nib(4'hF);
        load_nib(4'h7);
        check("gt ready", 32'(ready), 32'd1);
        run_cmp("gt80", LGE_G, lat_gt, LGE_E, 1'b0);
        run_cmp("gt80 again", LGE_G, lat_gt, LGE_G, 1'b0);

        // A = 0x12, B = 0x13: first difference at bit 0.
        load_nib(4'h2);
        load_nib(4'h1);
        load_nib(4'h3);
        load_nib(4'h1);
        run_cmp("lt12", LGE_L, 8, LGE_G, 1'b0);

        // Reset at edge k+4 during a compare aborts it without a done pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        saw = done;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) saw = 1'b1;
        end
        check("abort no done", 32'(saw), 32'd0);
        check("abort lge",     32'({l, g, e}), 32'(LGE_E));
        check("abort ready",   32'(ready), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start after rst", 32'(busy), 32'd0);

        // Refill A = 0x12, B = 0x13, then a fifth load rewrites only slot 0,
        // giving A = 0x13.
        load_nib(4'h2);
        load_nib(4'h1);
        load_nib(4'h3);
        load_nib(4'h1);
        check("refill ready", 32'(ready), 32'd1);
        load_nib(4'h3);
        check("5th load ready", 32'(ready), 32'd0);
        load_nib(4'h1);
        load_nib(4'h3);
        load_nib(4'h1);
        run_cmp("slot0 ovw", LGE_E, 8, LGE_E, 1'b0);

        // start and load together with ready set: start wins.
        load_nib(4'h2);
        load_nib(4'h1);
        load_nib(4'h3);
        load_nib(4'h1);
        inp  = 4'hF;
        load = 1'b1;
        run_cmp("start+load", LGE_L, 8, LGE_E, 1'b0);
        check("start+load ready", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
